// File: rtl/rggen_bit_field_rc_counter_pkg.sv
// Shared bit-field helpers and the counter's next-state action encoding.
package rggen_bit_field_rc_counter_pkg;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_CLEAR,
        CNT_INCR,
        CNT_OVERFLOW
    } cnt_action_e;

    function automatic logic is_write_access(
        input logic valid,
        input logic select,
        input logic write,
        input logic mask_any
    );
        return valid & select & write & mask_any;
    endfunction

    function automatic logic is_read_access(
        input logic valid,
        input logic select,
        input logic write
    );
        return valid & select & ~write;
    endfunction

endpackage

// File: rtl/rggen_bit_field_rc_counter_edge_detector.sv
// Event qualifier: passes i_event through as a level, or as its rising edge.
module rggen_event_edge_detector #(
    parameter int unsigned EVENT_EDGE = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_event,
    output logic o_event
);

    logic r_event_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_event_d <= 1'b0;
        end else begin
            r_event_d <= i_event;
        end
    end

    always_comb begin
        o_event = (EVENT_EDGE != 0) ? (i_event & ~r_event_d) : i_event;
    end

endmodule

// File: rtl/rggen_bit_field_rc_counter.sv
// Hardware-counted, software-read bit field with read/write/hardware clear,
// saturate-or-wrap overflow, sticky overflow flag and threshold interrupt.
module rggen_bit_field_rc_counter
    import rggen_bit_field_rc_counter_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned INITIAL_VALUE = 0,
    parameter int unsigned SATURATE      = 1,
    parameter int unsigned CLEAR_ON_READ = 1,
    parameter int unsigned EVENT_EDGE    = 0,
    parameter int unsigned THRESHOLD     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_command_valid,
    input  logic             i_select,
    input  logic             i_write,
    input  logic [WIDTH-1:0] i_write_data,
    input  logic [WIDTH-1:0] i_write_mask,
    input  logic             i_event,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_read_data,
    output logic [WIDTH-1:0] o_value,
    output logic             o_overflow,
    output logic             o_irq
);

    localparam logic [WIDTH-1:0] INIT_V = INITIAL_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0] r_counter;
    logic             r_overflow;
    logic             w_event;
    logic             w_read;
    logic             w_write;
    logic             w_clear;
    cnt_action_e      w_action;
    logic [WIDTH-1:0] w_counter_next;
    logic             w_overflow_next;
    logic             w_unused_write_data;

    // Any write clears the field; only the mask matters, never the data.
    assign w_unused_write_data = ^i_write_data;

    rggen_event_edge_detector #(
        .EVENT_EDGE (EVENT_EDGE)
    ) u_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_event (i_event),
        .o_event (w_event)
    );

    assign w_read  = is_read_access(i_command_valid, i_select, i_write);
    assign w_write = is_write_access(i_command_valid, i_select, i_write, |i_write_mask);
    assign w_clear = i_clear | w_write | (w_read & (CLEAR_ON_READ != 0));

    always_comb begin
        w_action = CNT_HOLD;
        if (w_clear) begin
            w_action = CNT_CLEAR;
        end else if (w_event) begin
            w_action = (r_counter == '1) ? CNT_OVERFLOW : CNT_INCR;
        end
    end

    always_comb begin
        w_counter_next  = r_counter;
        w_overflow_next = r_overflow;
        case (w_action)
            // A same-cycle event is folded into the cleared value.
            CNT_CLEAR: begin
                w_counter_next  = INIT_V + WIDTH'(w_event);
                w_overflow_next = 1'b0;
            end
            CNT_INCR: begin
                w_counter_next = r_counter + WIDTH'(1);
            end
            CNT_OVERFLOW: begin
                w_counter_next  = (SATURATE != 0) ? '1 : '0;
                w_overflow_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_counter  <= INIT_V;
            r_overflow <= 1'b0;
        end else begin
            r_counter  <= w_counter_next;
            r_overflow <= w_overflow_next;
        end
    end

    assign o_read_data = r_counter;
    assign o_value     = r_counter;
    assign o_overflow  = r_overflow;
    assign o_irq       = (THRESHOLD != 0) && (32'(r_counter) >= THRESHOLD);

endmodule

// File: tb/tb_rggen_bit_field_rc_counter.sv
// Five differently configured counters on shared stimulus, checked against a behavioural model.
module tb_rggen_bit_field_rc_counter;

    localparam int N = 5;
    localparam int unsigned CW  [N] = '{8, 4, 4, 8, 4};
    localparam int unsigned CINI[N] = '{0, 0, 0, 0, 3};
    localparam int unsigned CSAT[N] = '{1, 1, 0, 1, 0};
    localparam int unsigned CCOR[N] = '{1, 1, 0, 1, 1};
    localparam int unsigned CEDG[N] = '{0, 0, 0, 1, 1};
    localparam int unsigned CTHR[N] = '{3, 0, 0, 2, 5};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cv = 1'b0, sel = 1'b0, wr = 1'b0, ev = 1'b0, clr = 1'b0;
    logic [7:0] wd = '0, wm = '0;

    logic [7:0] a_rd, a_val, e_rd, e_val;
    logic [3:0] s_rd, s_val, w_rd, w_val, i_rd, i_val;
    logic       a_ovf, a_irq, s_ovf, s_irq, w_ovf, w_irq, e_ovf, e_irq, i_ovf, i_irq;

    logic [31:0] obs_val[N], obs_rd[N];
    logic        obs_ovf[N], obs_irq[N];

    int          passed = 0;
    int          total  = 0;
    int unsigned m_cnt [N];
    bit          m_ovf [N];
    bit          m_prev[N];

    always #5 clk = ~clk;

    rggen_bit_field_rc_counter #(.WIDTH(CW[0]), .INITIAL_VALUE(CINI[0]), .SATURATE(CSAT[0]),
        .CLEAR_ON_READ(CCOR[0]), .EVENT_EDGE(CEDG[0]), .THRESHOLD(CTHR[0])) u_a (
        .clk(clk), .rst_n(rst_n), .i_command_valid(cv), .i_select(sel), .i_write(wr),
        .i_write_data(wd), .i_write_mask(wm), .i_event(ev), .i_clear(clr),
        .o_read_data(a_rd), .o_value(a_val), .o_overflow(a_ovf), .o_irq(a_irq));
    rggen_bit_field_rc_counter #(.WIDTH(CW[1]), .INITIAL_VALUE(CINI[1]), .SATURATE(CSAT[1]),
        .CLEAR_ON_READ(CCOR[1]), .EVENT_EDGE(CEDG[1]), .THRESHOLD(CTHR[1])) u_s (
        .clk(clk), .rst_n(rst_n), .i_command_valid(cv), .i_select(sel), .i_write(wr),
        .i_write_data(wd[3:0]), .i_write_mask(wm[3:0]), .i_event(ev), .i_clear(clr),
        .o_read_data(s_rd), .o_value(s_val), .o_overflow(s_ovf), .o_irq(s_irq));
    rggen_bit_field_rc_counter #(.WIDTH(CW[2]), .INITIAL_VALUE(CINI[2]), .SATURATE(CSAT[2]),
        .CLEAR_ON_READ(CCOR[2]), .EVENT_EDGE(CEDG[2]), .THRESHOLD(CTHR[2])) u_w (
        .clk(clk), .rst_n(rst_n), .i_command_valid(cv), .i_select(sel), .i_write(wr),
        .i_write_data(wd[3:0]), .i_write_mask(wm[3:0]), .i_event(ev), .i_clear(clr),
        .o_read_data(w_rd), .o_value(w_val), .o_overflow(w_ovf), .o_irq(w_irq));
    rggen_bit_field_rc_counter #(.WIDTH(CW[3]), .INITIAL_VALUE(CINI[3]), .SATURATE(CSAT[3]),
        .CLEAR_ON_READ(CCOR[3]), .EVENT_EDGE(CEDG[3]), .THRESHOLD(CTHR[3])) u_e (
        .clk(clk), .rst_n(rst_n), .i_command_valid(cv), .i_select(sel), .i_write(wr),
        .i_write_data(wd), .i_write_mask(wm), .i_event(ev), .i_clear(clr),
        .o_read_data(e_rd), .o_value(e_val), .o_overflow(e_ovf), .o_irq(e_irq));
    rggen_bit_field_rc_counter #(.WIDTH(CW[4]), .INITIAL_VALUE(CINI[4]), .SATURATE(CSAT[4]),
        .CLEAR_ON_READ(CCOR[4]), .EVENT_EDGE(CEDG[4]), .THRESHOLD(CTHR[4])) u_i (
        .clk(clk), .rst_n(rst_n), .i_command_valid(cv), .i_select(sel), .i_write(wr),
        .i_write_data(wd[3:0]), .i_write_mask(wm[3:0]), .i_event(ev), .i_clear(clr),
        .o_read_data(i_rd), .o_value(i_val), .o_overflow(i_ovf), .o_irq(i_irq));

    assign obs_val[0] = 32'(a_val); assign obs_rd[0] = 32'(a_rd);
    assign obs_val[1] = 32'(s_val); assign obs_rd[1] = 32'(s_rd);
    assign obs_val[2] = 32'(w_val); assign obs_rd[2] = 32'(w_rd);
    assign obs_val[3] = 32'(e_val); assign obs_rd[3] = 32'(e_rd);
    assign obs_val[4] = 32'(i_val); assign obs_rd[4] = 32'(i_rd);
    assign obs_ovf[0] = a_ovf; assign obs_irq[0] = a_irq;
    assign obs_ovf[1] = s_ovf; assign obs_irq[1] = s_irq;
    assign obs_ovf[2] = w_ovf; assign obs_irq[2] = w_irq;
    assign obs_ovf[3] = e_ovf; assign obs_irq[3] = e_irq;
    assign obs_ovf[4] = i_ovf; assign obs_irq[4] = i_irq;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    endtask

    task automatic check_all(input string phase);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s_val%0d", phase, k), obs_val[k], 32'(m_cnt[k]));
            chk($sformatf("%s_rd%0d", phase, k), obs_rd[k], 32'(m_cnt[k]));
            chk($sformatf("%s_ovf%0d", phase, k), 32'(obs_ovf[k]), 32'(m_ovf[k]));
            chk($sformatf("%s_irq%0d", phase, k), 32'(obs_irq[k]),
                32'((CTHR[k] != 0) && (m_cnt[k] >= CTHR[k])));
        end
    endtask

    // Model: apply one clock edge's worth of rules to every configuration.
    task automatic step(input string phase);
        int unsigned n_cnt[N];
        bit          n_ovf[N], n_prev[N];
        for (int k = 0; k < N; k++) begin
            int unsigned top = (1 << CW[k]) - 1;
            bit rd_acc = cv && sel && !wr;
            bit wr_acc = cv && sel && wr && ((32'(wm) & top) != 0);
            bit e_q    = (CEDG[k] != 0) ? (ev && !m_prev[k]) : ev;
            bit do_clr = clr || wr_acc || (rd_acc && CCOR[k] != 0);
            n_cnt[k] = m_cnt[k];
            n_ovf[k] = m_ovf[k];
            if (!rst_n) begin
                n_cnt[k] = CINI[k];
                n_ovf[k] = 1'b0;
                n_prev[k] = 1'b0;
            end else begin
                if (do_clr) begin
                    n_cnt[k] = (CINI[k] + (e_q ? 1 : 0)) % (top + 1);
                    n_ovf[k] = 1'b0;
                end else if (e_q) begin
                    if (m_cnt[k] + 1 > top) begin
                        n_cnt[k] = (CSAT[k] != 0) ? top : 0;
                        n_ovf[k] = 1'b1;
                    end else begin
                        n_cnt[k] = m_cnt[k] + 1;
                    end
                end
                n_prev[k] = ev;
            end
        end
        @(posedge clk);
        #1;
        m_cnt  = n_cnt;
        m_ovf  = n_ovf;
        m_prev = n_prev;
        check_all(phase);
    endtask

    task automatic drive(input logic v, input logic s, input logic w, input logic [7:0] m,
                         input logic e, input logic c);
        cv = v; sel = s; wr = w; wm = m; ev = e; clr = c;
        wd = 8'($urandom);
    endtask

    initial begin
        bit pat[7] = '{1, 1, 1, 1, 0, 0, 1};
        for (int k = 0; k < N; k++) begin
            m_cnt[k] = 0; m_ovf[k] = 0; m_prev[k] = 0;
        end
        #1;
        rst_n = 1'b0;
        drive(0, 0, 0, 8'h00, 0, 0);
        step("rst");
        step("rst");
        rst_n = 1'b1;

        // Level counting 1..5 after reset
        drive(0, 0, 0, 8'h00, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            step("cnt");
            chk("t1_val", 32'(a_val), 32'(i));
        end
        chk("t1_ovf", 32'(a_ovf), 32'h0);

        // Read-to-clear returns pre-clear value
        drive(1, 1, 0, 8'h00, 0, 0);
        chk("t2_rd_pre", 32'(a_rd), 32'd5);
        step("rc");
        chk("t2_clr", 32'(a_val), 32'd0);
        drive(0, 0, 0, 8'h00, 1, 0);
        repeat (3) step("cnt");
        drive(1, 1, 0, 8'h00, 1, 0);
        step("rc_ev");
        chk("t2_clr_ev", 32'(a_val), 32'd1);

        drive(1, 1, 1, 8'h01, 0, 0);
        step("wclr");

        // Wrap and non-destructive read
        drive(0, 0, 0, 8'h00, 1, 0);
        repeat (15) step("wrap");
        chk("t4_w15", 32'(w_val), 32'd15);
        step("wrap");
        chk("t4_w0", 32'(w_val), 32'd0);
        chk("t4_wovf", 32'(w_ovf), 32'd1);
        drive(1, 1, 0, 8'h00, 0, 0);
        step("rd_nc");
        chk("t4_rd_val", 32'(w_val), 32'd0);
        chk("t4_rd_ovf", 32'(w_ovf), 32'd1);

        // Saturate then write-clear
        drive(0, 0, 0, 8'h00, 1, 0);
        repeat (18) step("sat");
        chk("t3_s15", 32'(s_val), 32'd15);
        chk("t3_sovf", 32'(s_ovf), 32'd1);
        drive(1, 1, 1, 8'h01, 0, 0);
        step("wclr");
        chk("t3_s0", 32'(s_val), 32'd0);
        chk("t3_sovf0", 32'(s_ovf), 32'd0);

        // Edge counting and threshold interrupt
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0, 8'h00, pat[i], 0);
            if (i == 6) begin
                chk("t5_pre_val", 32'(e_val), 32'd1);
                chk("t5_pre_irq", 32'(e_irq), 32'd0);
            end
            step("edge");
        end
        chk("t5_val", 32'(e_val), 32'd2);
        chk("t5_irq", 32'(e_irq), 32'd1);

        // Clear precedence
        drive(1, 1, 0, 8'h00, 0, 1);
        step("hclr");
        chk("t6_hclr", 32'(a_val), 32'd0);
        drive(0, 0, 0, 8'h00, 1, 1);
        step("hclr_ev");
        chk("t6_hclr_ev", 32'(a_val), 32'd1);
        chk("t6_init_ev", 32'(i_val), 32'd4);
        rst_n = 1'b0;
        drive(1, 1, 1, 8'hff, 1, 0);
        step("rst_mid");
        chk("t6_rst_init", 32'(i_val), 32'd3);
        chk("t6_rst_ovf", 32'(w_ovf), 32'd0);
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            drive(($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
            step("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
